// File: rtl/alu_decode_exec.sv
`default_nettype none
// ============================================================================
// Module   : alu_decode_exec
// Brief    : RISC-V style ALU decoder + execute unit with valid/ready handshake.
//            Shifts are single-cycle (FAST_SHIFT=1) or iterative at 1 bit/cycle.
// Revision : 1.0 - initial release
// ============================================================================
module alu_decode_exec #(
    parameter int XLEN       = 32,
    parameter int FAST_SHIFT = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      alu_op,
    input  logic [2:0]      funct3,
    input  logic            funct7b5,
    input  logic            opb5,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    localparam int c_SHW = $clog2(XLEN);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHIFT = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    localparam logic [1:0] c_SK_SLL = 2'd0;
    localparam logic [1:0] c_SK_SRL = 2'd1;
    localparam logic [1:0] c_SK_SRA = 2'd2;

    logic [1:0]       r_state_q,   w_state_d;
    logic [XLEN-1:0]  r_result_q,  w_result_d;
    logic [c_SHW-1:0] r_cnt_q,     w_cnt_d;
    logic             r_illegal_q, w_illegal_d;
    logic [1:0]       r_kind_q,    w_kind_d;

    logic             w_illegal;
    logic             w_is_shift;
    logic [1:0]       w_kind;
    logic [c_SHW-1:0] w_amt;
    logic [XLEN-1:0]  w_calc;
    logic             w_iterative;

    // Decode the request and compute the single-cycle result (incl. fast shifts)
    always_comb begin
        w_illegal  = 1'b0;
        w_is_shift = 1'b0;
        w_kind     = c_SK_SLL;
        w_amt      = src_b[c_SHW-1:0];
        w_calc     = '0;
        case (alu_op)
            2'b00: w_calc = src_a + src_b;
            2'b01: w_calc = src_a - src_b;
            2'b10: begin
                case (funct3)
                    3'b000: w_calc = (funct7b5 && opb5) ? (src_a - src_b) : (src_a + src_b);
                    3'b001: begin
                        if (funct7b5) begin
                            w_illegal = 1'b1;
                        end else begin
                            w_is_shift = 1'b1;
                            w_kind     = c_SK_SLL;
                            w_calc     = src_a << w_amt;
                        end
                    end
                    3'b010: w_calc = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
                    3'b011: w_calc = {{(XLEN-1){1'b0}}, (src_a < src_b)};
                    3'b100: w_calc = src_a ^ src_b;
                    3'b101: begin
                        w_is_shift = 1'b1;
                        if (funct7b5) begin
                            w_kind = c_SK_SRA;
                            w_calc = $signed(src_a) >>> w_amt;
                        end else begin
                            w_kind = c_SK_SRL;
                            w_calc = src_a >> w_amt;
                        end
                    end
                    3'b110: w_calc = src_a | src_b;
                    default: w_calc = src_a & src_b;
                endcase
            end
            default: w_illegal = 1'b1;
        endcase
    end

    // Only nonzero shifts in the iterative build take the multi-cycle path;
    // a zero-amount shift already has its answer (src_a) in w_calc.
    assign w_iterative = w_is_shift && (FAST_SHIFT == 0) && (w_amt != '0);

    // Next-state logic: accept in IDLE, shift one bit per cycle, hold in DONE
    always_comb begin
        w_state_d   = r_state_q;
        w_result_d  = r_result_q;
        w_cnt_d     = r_cnt_q;
        w_illegal_d = r_illegal_q;
        w_kind_d    = r_kind_q;
        case (r_state_q)
            c_IDLE: begin
                if (in_valid) begin
                    w_illegal_d = w_illegal;
                    w_kind_d    = w_kind;
                    if (w_iterative) begin
                        w_state_d  = c_SHIFT;
                        w_result_d = src_a;
                        w_cnt_d    = w_amt;
                    end else begin
                        w_state_d  = c_DONE;
                        w_result_d = w_calc;
                        w_cnt_d    = '0;
                    end
                end
            end
            c_SHIFT: begin
                case (r_kind_q)
                    c_SK_SLL: w_result_d = {r_result_q[XLEN-2:0], 1'b0};
                    c_SK_SRL: w_result_d = {1'b0, r_result_q[XLEN-1:1]};
                    default:  w_result_d = {r_result_q[XLEN-1], r_result_q[XLEN-1:1]};
                endcase
                w_cnt_d = r_cnt_q - c_SHW'(1);
                if (r_cnt_q == c_SHW'(1)) begin
                    w_state_d = c_DONE;
                end
            end
            c_DONE: begin
                if (out_ready) begin
                    w_state_d = c_IDLE;
                end
            end
            default: w_state_d = c_IDLE;
        endcase
    end

    // State registers; reset aborts any operation in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q   <= c_IDLE;
            r_result_q  <= '0;
            r_cnt_q     <= '0;
            r_illegal_q <= 1'b0;
            r_kind_q    <= c_SK_SLL;
        end else begin
            r_state_q   <= w_state_d;
            r_result_q  <= w_result_d;
            r_cnt_q     <= w_cnt_d;
            r_illegal_q <= w_illegal_d;
            r_kind_q    <= w_kind_d;
        end
    end

    assign in_ready  = (r_state_q == c_IDLE);
    assign out_valid = (r_state_q == c_DONE);
    assign result    = r_result_q;
    assign zero      = (r_result_q == '0);
    assign illegal   = r_illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_decode_exec.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_decode_exec
// Brief    : Directed self-checking bench for alu_decode_exec (iterative and
//            fast-shift builds, XLEN=32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_decode_exec;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_valid_f;
    logic [1:0]  alu_op;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        opb5;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        out_ready;

    logic        in_ready,  out_valid,  zero,  illegal;
    logic [31:0] result;
    logic        f_in_ready, f_out_valid, f_zero, f_illegal;
    logic [31:0] f_result;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    alu_decode_exec #(.XLEN(32), .FAST_SHIFT(0)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .funct3(funct3), .funct7b5(funct7b5), .opb5(opb5),
        .src_a(src_a), .src_b(src_b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .illegal(illegal)
    );

    alu_decode_exec #(.XLEN(32), .FAST_SHIFT(1)) dut_f (
        .clk(clk), .reset(reset), .in_valid(in_valid_f), .in_ready(f_in_ready),
        .alu_op(alu_op), .funct3(funct3), .funct7b5(funct7b5), .opb5(opb5),
        .src_a(src_a), .src_b(src_b), .out_valid(f_out_valid), .out_ready(out_ready),
        .result(f_result), .zero(f_zero), .illegal(f_illegal)
    );

    // Present one request for exactly one edge; caller is #1 past an edge with the target idle
    task automatic issue(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                         input logic ob, input logic [31:0] a, input logic [31:0] b,
                         input bit fast);
        alu_op = op; funct3 = f3; funct7b5 = f7; opb5 = ob; src_a = a; src_b = b;
        if (fast) in_valid_f = 1'b1; else in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid   = 1'b0;
        in_valid_f = 1'b0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        n_total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'h0 || zero !== 1'b1 || illegal !== 1'b0)
            $display("FAIL reset_state got rdy=%b vld=%b res=%h z=%b ill=%b exp 1 0 0 1 0",
                     in_ready, out_valid, result, zero, illegal);
        else n_pass++;
    endtask

    task automatic test_add();
        out_ready = 1'b1;
        issue(2'b10, 3'b000, 1'b1, 1'b0, 32'd5, 32'd7, 1'b0);
        n_total++;
        if (out_valid !== 1'b1 || result !== 32'd12 || zero !== 1'b0 || illegal !== 1'b0)
            $display("FAIL addi got vld=%b res=%h z=%b ill=%b exp 1 0000000c 0 0", out_valid, result, zero, illegal);
        else n_pass++;
        step();
        n_total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL addi_return got rdy=%b vld=%b exp 1 0", in_ready, out_valid);
        else n_pass++;
        issue(2'b00, 3'b111, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0);
        n_total++;
        if (result !== 32'h0 || zero !== 1'b1)
            $display("FAIL add_wrap got res=%h z=%b exp 00000000 1", result, zero);
        else n_pass++;
        step();
    endtask

    task automatic test_sub_slt();
        issue(2'b01, 3'b000, 1'b0, 1'b0, 32'h1234, 32'h1234, 1'b0);
        n_total++;
        if (result !== 32'h0 || zero !== 1'b1)
            $display("FAIL sub_zero got res=%h z=%b exp 00000000 1", result, zero);
        else n_pass++;
        step();
        issue(2'b10, 3'b000, 1'b1, 1'b1, 32'd10, 32'd3, 1'b0);
        n_total++;
        if (result !== 32'd7) $display("FAIL rtype_sub got %h exp 00000007", result);
        else n_pass++;
        step();
        issue(2'b10, 3'b010, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1, 1'b0);
        n_total++;
        if (result !== 32'd1) $display("FAIL slt got %h exp 00000001", result);
        else n_pass++;
        step();
        issue(2'b10, 3'b011, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1, 1'b0);
        n_total++;
        if (result !== 32'd0 || zero !== 1'b1) $display("FAIL sltu got res=%h z=%b exp 00000000 1", result, zero);
        else n_pass++;
        step();
    endtask

    task automatic test_logic();
        issue(2'b10, 3'b100, 1'b0, 1'b1, 32'hF0F0_1234, 32'h0FF0_00FF, 1'b0);
        n_total++;
        if (result !== 32'hFF00_12CB) $display("FAIL xor got %h exp ff0012cb", result);
        else n_pass++;
        step();
        issue(2'b10, 3'b110, 1'b0, 1'b1, 32'hF0F0_1234, 32'h0FF0_00FF, 1'b0);
        n_total++;
        if (result !== 32'hFFF0_12FF) $display("FAIL or got %h exp fff012ff", result);
        else n_pass++;
        step();
        issue(2'b10, 3'b111, 1'b0, 1'b1, 32'hF0F0_1234, 32'h0FF0_00FF, 1'b0);
        n_total++;
        if (result !== 32'h00F0_0034) $display("FAIL and got %h exp 00f00034", result);
        else n_pass++;
        step();
    endtask

    // Iterative shifts: measure accept-to-out_valid latency and final value
    task automatic test_iter_shift();
        logic [2:0]  f3s  [4] = '{3'b101, 3'b001, 3'b101, 3'b101};
        logic        f7s  [4] = '{1'b1,   1'b0,   1'b0,   1'b1};
        logic [31:0] as   [4] = '{32'h8000_0000, 32'h1, 32'h8000_0000, 32'h1234_5678};
        logic [31:0] bs   [4] = '{32'h24, 32'hFFFF_FFE3, 32'd31, 32'h20};
        logic [31:0] exps [4] = '{32'hF800_0000, 32'h8, 32'h1, 32'h1234_5678};
        int          lats [4] = '{5, 4, 32, 1};
        for (int i = 0; i < 4; i++) begin
            int lat;
            bit busy_ok;
            issue(2'b10, f3s[i], f7s[i], 1'b1, as[i], bs[i], 1'b0);
            lat = 1;
            busy_ok = 1'b1;
            while (out_valid !== 1'b1 && lat < 40) begin
                if (in_ready !== 1'b0) busy_ok = 1'b0;
                step();
                lat++;
            end
            n_total++;
            if (lat !== lats[i] || result !== exps[i] || in_ready !== 1'b0 || !busy_ok)
                $display("FAIL shift%0d got lat=%0d res=%h rdy=%b busy_ok=%b exp lat=%0d res=%h rdy=0 busy_ok=1",
                         i, lat, result, in_ready, busy_ok, lats[i], exps[i]);
            else n_pass++;
            step();
            n_total++;
            if (in_ready !== 1'b1) $display("FAIL shift%0d_idle got rdy=%b exp 1", i, in_ready);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        bit stable = 1'b1;
        out_ready = 1'b0;
        issue(2'b00, 3'b000, 1'b0, 1'b0, 32'd3, 32'd4, 1'b0);
        for (int i = 0; i < 10; i++) begin
            if (out_valid !== 1'b1 || result !== 32'd7 || in_ready !== 1'b0) stable = 1'b0;
            in_valid = i[0];
            src_a    = 32'd100;
            step();
        end
        n_total++;
        if (!stable || out_valid !== 1'b1 || result !== 32'd7)
            $display("FAIL backpressure_hold got stable=%b vld=%b res=%h exp 1 1 00000007", stable, out_valid, result);
        else n_pass++;
        // Release the result while a request is already waiting: it must not be taken this cycle
        alu_op = 2'b00; src_a = 32'd100; src_b = 32'd1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        n_total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL backpressure_release got rdy=%b vld=%b exp 1 0", in_ready, out_valid);
        else n_pass++;
        step();
        in_valid = 1'b0;
        n_total++;
        if (out_valid !== 1'b1 || result !== 32'd101)
            $display("FAIL after_release got vld=%b res=%h exp 1 00000065", out_valid, result);
        else n_pass++;
        step();
    endtask

    task automatic test_illegal();
        issue(2'b11, 3'b000, 1'b0, 1'b0, 32'd5, 32'd5, 1'b0);
        n_total++;
        if (out_valid !== 1'b1 || illegal !== 1'b1 || result !== 32'h0 || zero !== 1'b1)
            $display("FAIL illegal_op got vld=%b ill=%b res=%h z=%b exp 1 1 00000000 1", out_valid, illegal, result, zero);
        else n_pass++;
        step();
        issue(2'b10, 3'b001, 1'b1, 1'b1, 32'd5, 32'd2, 1'b0);
        n_total++;
        if (out_valid !== 1'b1 || illegal !== 1'b1 || result !== 32'h0)
            $display("FAIL illegal_sll got vld=%b ill=%b res=%h exp 1 1 00000000", out_valid, illegal, result);
        else n_pass++;
        step();
        issue(2'b00, 3'b000, 1'b0, 1'b0, 32'd1, 32'd1, 1'b0);
        n_total++;
        if (illegal !== 1'b0 || result !== 32'd2)
            $display("FAIL illegal_clear got ill=%b res=%h exp 0 00000002", illegal, result);
        else n_pass++;
        step();
    endtask

    task automatic test_reset_abort();
        bit quiet = 1'b1;
        issue(2'b10, 3'b101, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd31, 1'b0);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'h0)
            $display("FAIL reset_mid_shift got rdy=%b vld=%b res=%h exp 1 0 00000000", in_ready, out_valid, result);
        else n_pass++;
        for (int i = 0; i < 35; i++) begin
            if (out_valid !== 1'b0) quiet = 1'b0;
            step();
        end
        n_total++;
        if (!quiet) $display("FAIL reset_discard got stray out_valid exp none");
        else n_pass++;
        issue(2'b00, 3'b000, 1'b0, 1'b0, 32'd2, 32'd3, 1'b0);
        n_total++;
        if (out_valid !== 1'b1 || result !== 32'd5)
            $display("FAIL post_reset_add got vld=%b res=%h exp 1 00000005", out_valid, result);
        else n_pass++;
        step();
        out_ready = 1'b0;
        issue(2'b00, 3'b000, 1'b0, 1'b0, 32'd9, 32'd9, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        out_ready = 1'b1;
        n_total++;
        if (out_valid !== 1'b0 || result !== 32'h0 || in_ready !== 1'b1)
            $display("FAIL reset_in_done got vld=%b res=%h rdy=%b exp 0 00000000 1", out_valid, result, in_ready);
        else n_pass++;
    endtask

    task automatic test_fast_shift();
        out_ready = 1'b1;
        issue(2'b10, 3'b101, 1'b1, 1'b1, 32'h8000_0000, 32'h24, 1'b1);
        n_total++;
        if (f_out_valid !== 1'b1 || f_result !== 32'hF800_0000)
            $display("FAIL fast_sra got vld=%b res=%h exp 1 f8000000", f_out_valid, f_result);
        else n_pass++;
        step();
        issue(2'b10, 3'b001, 1'b0, 1'b0, 32'd3, 32'd33, 1'b1);
        n_total++;
        if (f_out_valid !== 1'b1 || f_result !== 32'd6)
            $display("FAIL fast_sll got vld=%b res=%h exp 1 00000006", f_out_valid, f_result);
        else n_pass++;
        step();
        issue(2'b10, 3'b101, 1'b0, 1'b1, 32'hF000_0000, 32'd28, 1'b1);
        n_total++;
        if (f_out_valid !== 1'b1 || f_result !== 32'hF)
            $display("FAIL fast_srl got vld=%b res=%h exp 1 0000000f", f_out_valid, f_result);
        else n_pass++;
        step();
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_valid_f = 1'b0;
        alu_op = 2'b00; funct3 = 3'b000; funct7b5 = 1'b0; opb5 = 1'b0;
        src_a = '0; src_b = '0; out_ready = 1'b1;
        test_reset();
        test_add();
        test_sub_slt();
        test_logic();
        test_iter_shift();
        test_backpressure();
        test_illegal();
        test_reset_abort();
        test_fast_shift();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
